muldiv_unit: RTL
================

// Module: muldiv_unit
// PURPOSE
//   Multi-cycle multiply/divide unit with architectural HI/LO registers, sitting beside the
//   single-cycle ALU in EX. Executes MULT/MULTU/DIV/DIVU and MTHI/MTLO, and drives busy
//   so the hazard unit stalls MFHI/MFLO and further mul/div ops until results commit.
//   A flush cancels an in-flight op on exceptions.
// PARAMETERS
//   WIDTH        32  operand width; HI/LO are each WIDTH bits
//   MUL_LATENCY  5   cycles from start edge to HI/LO commit for MULT/MULTU (>=1)
// PORTS
//   clk    in   1      rising-edge clock
//   reset  in   1      synchronous, active-high
//   start  in   1      launch op in ctrl with A/B; sampled only while busy=0
//   ctrl   in   3      `mdNone/`mdMult/`mdMultu/`mdDiv/`mdDivu/`mdMthi/`mdMtlo
//   A      in   WIDTH  multiplicand / dividend / MTHI-MTLO data
//   B      in   WIDTH  multiplier / divisor
//   flush  in   1      abort in-flight op; HI/LO keep pre-op values
//   busy   out  1      op in flight; HI/LO not yet valid
//   done   out  1      one-cycle pulse in the cycle after HI/LO commit
//   hi     out  WIDTH  HI register (registered)
//   lo     out  WIDTH  LO register (registered)
// BEHAVIOUR
//   - Single clock; reset synchronous and active-high. Reset: hi=0, lo=0, busy=0, done=0,
//     FSM=IDLE, counter=0. Reset mid-op discards the op.
//   - FSM states: IDLE, MUL, DIV, FIX.
//   - IDLE + start + mult/multu (edge E0): product of A*B (signed for mult) latched into a
//     2*WIDTH holding register; counter=MUL_LATENCY-1; -> MUL; busy=1 after E0.
//   - MUL: counter decrements each edge; at counter==0 edge {hi,lo}<=product, -> IDLE,
//     busy=0, done=1 for one cycle. Net: commit at edge E0+MUL_LATENCY.
//   - IDLE + start + div/divu: operands latched (signed: magnitudes + sign bits), -> DIV.
//     DIV runs WIDTH restoring shift-subtract iterations, one per edge, then FIX applies
//     signs (quotient sign = sA^sB, remainder sign = sA) and commits lo=quot, hi=rem.
//     Commit at edge E0+WIDTH+1; busy high WIDTH+1 cycles; done pulses after.
//   - Divide by zero (B==0): full latency still used; lo=all ones, hi=A. No exception.
//   - Signed overflow (A=MIN, B=-1): lo=MIN, hi=0.
//   - mthi/mtlo with start in IDLE: hi (or lo) <= A at that edge; busy stays 0; done=0.
//   - start with ctrl=`mdNone, or start while busy=1: ignored (no state change).
//   - flush: at next edge FSM -> IDLE, busy=0, done=0, hi/lo unchanged. flush with start
//     in same cycle: flush wins, start ignored. flush in IDLE: no effect.
//   - done is never asserted in the same cycle as busy.
//   - All arithmetic modulo WIDTH per half; no internal state wider than 2*WIDTH+1.
// STRUCTURE
//   - constants.v gains `mdNone..`mdMtlo encodings (3 bits) next to the `alu* codes.
//   - One sub-module: serial_divider (WIDTH param; start, operands in; quotient,
//     remainder, valid out; unsigned core only). Sign handling and multiply stay here.
//   - Target 200-300 lines total.
// TESTING (WIDTH=32, MUL_LATENCY=5)
//   - reset, then idle 3 cycles -> hi=0, lo=0, busy=0, done=0 throughout.
//   - multu A=0xFFFFFFFF B=0xFFFFFFFF -> busy 5 cycles, then hi=0xFFFFFFFE lo=0x00000001.
//   - div A=-7 B=2 -> busy 33 cycles, lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1), done pulse.
//   - divu A=0x1234 B=0 -> lo=0xFFFFFFFF hi=0x1234; div A=0x80000000 B=-1 -> lo=0x80000000 hi=0.
//   - mthi A=0xDEADBEEF then mult started, flush at cycle 2 -> busy=0 next cycle,
//     hi=0xDEADBEEF unchanged, no done pulse; second start during busy ignored.
//   - reset asserted mid-div (cycle 10) -> next cycle busy=0, hi=lo=0; new mult works.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the multiply/divide unit: op codes on ctrl and FSM states.
package muldiv_unit_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } md_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/muldiv_unit_serial_divider.sv
// Unsigned restoring divider: loads on start, then one shift-subtract step per clock.
module serial_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             valid
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    cnt;
  logic             running;
  logic [WIDTH-1:0] q_p0, r_p0, d_p0;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] r_next;
  logic             q_bit;

  // The partial remainder is always below the divisor, so the trial fits in WIDTH+1 bits.
  always_comb begin
    trial  = {r_p0, q_p0[WIDTH-1]};
    r_next = trial[WIDTH-1:0];
    q_bit  = 1'b0;
    if (trial >= {1'b0, d_p0}) begin
      r_next = trial[WIDTH-1:0] - d_p0;
      q_bit  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      running <= 1'b0;
    end else if (start) begin
      cnt     <= CW'(WIDTH);
      running <= 1'b1;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      q_p0 <= dividend;
      r_p0 <= '0;
      d_p0 <= divisor;
    end else if (cnt != '0) begin
      q_p0 <= {q_p0[WIDTH-2:0], q_bit};
      r_p0 <= r_next;
    end
  end

  assign quotient  = q_p0;
  assign remainder = r_p0;
  assign valid     = running && (cnt == '0);

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO, plus MTHI/MTLO.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MUL_LATENCY = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       ctrl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(max_u(WIDTH, MUL_LATENCY) + 1);

  md_state_e          state;
  md_op_e             op;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] prod_p0;
  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic               sign_q, sign_r, div_zero;
  logic               launch, div_start, div_signed;
  logic [WIDTH-1:0]   mag_a, mag_b, quot, rem;
  logic               div_valid;

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  assign op         = md_op_e'(ctrl);
  assign launch     = (state == S_IDLE) && start && !flush;
  assign div_signed = (op == MD_DIV);
  assign div_start  = launch && ((op == MD_DIV) || (op == MD_DIVU));

  assign prod_s = $signed({{WIDTH{A[WIDTH-1]}}, A}) * $signed({{WIDTH{B[WIDTH-1]}}, B});
  assign prod_u = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};

  // The core divides magnitudes; signs are reapplied in FIX.
  assign mag_a = (div_signed && A[WIDTH-1]) ? -A : A;
  assign mag_b = (div_signed && B[WIDTH-1]) ? -B : B;

  serial_divider #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (mag_a),
    .divisor  (mag_b),
    .quotient (quot),
    .remainder(rem),
    .valid    (div_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (launch) begin
            unique case (op)
              MD_MULT, MD_MULTU: begin
                prod_p0 <= (op == MD_MULT) ? prod_s : prod_u;
                cnt     <= CNT_W'(MUL_LATENCY - 1);
                state   <= S_MUL;
                busy    <= 1'b1;
              end
              MD_DIV, MD_DIVU: begin
                sign_q   <= div_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
                sign_r   <= div_signed && A[WIDTH-1];
                div_zero <= (B == '0);
                cnt      <= CNT_W'(WIDTH - 1);
                state    <= S_DIV;
                busy     <= 1'b1;
              end
              MD_MTHI: hi <= A;
              MD_MTLO: lo <= A;
              default: ;
            endcase
          end
        end
        // Multiply: product already held, just count out the latency.
        S_MUL: begin
          if (flush) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (cnt == '0) begin
            {hi, lo} <= prod_p0;
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_DIV: begin
          if (flush) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (cnt == '0) begin
            state <= S_FIX;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        // Remainder follows the dividend sign, so divide-by-zero naturally returns hi=A.
        S_FIX: begin
          if (flush) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (div_valid) begin
            lo    <= div_zero ? '1 : apply_sign(quot, sign_q);
            hi    <= apply_sign(rem, sign_r);
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
